sd_wb_dma: RTL and testbench
============================

Name: sd_wb_dma

Overview:
Parametrised Wishbone burst-DMA engine that moves one SD data block between a local dual-port block buffer and system memory. It succeeds the single-beat block mover inside the SD device top level. Data width is fixed at 32 bits. Buffer depth, burst length and ack timeout are configurable, and both directions share one engine. It sits between the SD block manager (buffer side) and the system Wishbone bus.

Parameters:
BUF_AW, 7, buffer word-address width; block = 2^BUF_AW 32-bit words (128 words = 512 B).
BURST_LEN, 8, words per Wishbone burst; power of 2, 1..2^BUF_AW.
TIMEOUT_CYC, 1024, cycles of stb without ack/err before abort; 0 disables the timeout.

Ports:
clk_50  in  1  system and Wishbone clock
reset_n  in  1  asynchronous active-low reset
xfer_go  in  1  start pulse; sampled only in IDLE
xfer_dir  in  1  0 = bus->buffer (memory read), 1 = buffer->bus (memory write); sampled with go
xfer_addr  in  32  block byte base address; bits[1:0] forced 0
xfer_busy  out  1  high from the cycle after accepted go until done
xfer_done  out  1  one-cycle completion pulse
xfer_err  out  1  valid with done; 1 = aborted by err_i or timeout
buf_rd_addr  out  BUF_AW  buffer read address; 1-cycle registered-read latency
buf_rd_q  in  32  buffer read data
buf_wr_addr  out  BUF_AW  buffer write address
buf_wr_en  out  1  buffer write strobe
buf_wr_data  out  32  buffer write data
wbm_adr_o  out  32  byte address
wbm_dat_i  in  32  read data
wbm_dat_o  out  32  write data
wbm_sel_o  out  4  always 4'hF
wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone controls
wbm_ack_i, wbm_err_i  in  1 each  Wishbone responses
wbm_cti_o  out  3  cycle type
wbm_bte_o  out  2  always 2'b00

Behaviour:
- Clock and reset: single clock clk_50. reset_n is asynchronous, active-low.
- Reset values:
  - All outputs 0 except wbm_sel_o = 4'hF.
  - State = IDLE; word index idx = 0.
  - Reset mid-transfer drops cyc/stb immediately (asynchronously). No done pulse is produced.
- States: IDLE, PREF, BURST, GAP, WBUF, FIN.
- IDLE:
  - Accept go: latch dir and base address, clear idx, assert busy.
  - dir=0 goes to BURST. dir=1 goes to PREF.
  - go outside IDLE is ignored.
- PREF: buf_rd_addr = 0 for one cycle, then BURST. So cyc rises 1 cycle after go for dir=0 and 2 cycles after go for dir=1.
- BURST:
  - cyc = stb = 1; we = dir.
  - wbm_adr_o = base + {idx, 2'b00}.
  - cti = 3'b010 on all beats except the last beat of the burst, which uses 3'b111. If BURST_LEN = 1, cti = 3'b000.
  - On ack, idx increments (wraps to 0 after the last word).
- Write path (dir=1):
  - buf_rd_addr = ack ? idx+1 : idx (combinational).
  - wbm_dat_o = buf_rd_q.
  - Result: no bubbles between beats.
- Read path (dir=0):
  - On ack, the next cycle drives buf_wr_en = 1, buf_wr_addr = idx of the acked beat, buf_wr_data = registered wbm_dat_i.
- After the last beat of a burst:
  - If block words remain, go to GAP. GAP holds cyc = 0 for exactly 1 cycle, then BURST.
  - After the final word: dir=0 goes to WBUF (1 cycle, for the last buffer write), then FIN. dir=1 goes to FIN directly.
- FIN: done = 1 for one cycle with err = 0; busy cleared the same cycle; then IDLE.
- Abort:
  - Cause: err_i while stb is high, or the timeout counter reaching TIMEOUT_CYC.
  - Next cycle: cyc = stb = 0, done = 1, err = 1, then IDLE. No further buffer writes occur.
  - If ack and err_i arrive in the same cycle, err wins and the beat is discarded.
- Timeout counter: clears on every ack and in GAP; counts while stb is high.
- Address arithmetic: modulo 2^32. No 4 KB boundary check; bte is always linear.

Decomposition:
- Package sd_dma_pkg:
  - state enum.
  - CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111.
  - BTE_LINEAR = 2'b00.
  - Function clog2.
- Sub-module sd_dma_timeout: loadable counter with enable, clear and expire flag, parameterised by TIMEOUT_CYC.

Test Plan:
- Read, defaults: dir=0, addr=0x1000_0000, slave acks every cycle → 16 bursts of 8 beats, addresses 0x1000_0000..0x1000_01FC; 1-cycle cyc gap between bursts; cti 010×7 then 111; buffer holds words 0..127 in order; done = 1, err = 0 at cycle 146.
- Write, wait states: dir=1, buffer pre-filled with word i = 0xA5000000+i, slave acks every 3rd cycle → wbm_dat_o matches buffer on every ack; we = 1; done once, err = 0.
- Bus error: err_i on beat 37 of a read → cyc falls next cycle; done = err = 1; buffer words 37..127 unchanged.
- Timeout: TIMEOUT_CYC = 16, slave never acks → abort 16 cycles after stb rises; done = err = 1; busy cleared.
- Overlap and reset: go pulsed mid-transfer is ignored; reset_n asserted mid-burst → cyc = 0 asynchronously, no done; a fresh go afterwards completes normally.
- BURST_LEN = 1, BUF_AW = 2: 4 classic cycles with cti = 000 and a gap between each.

Source files
------------

// File: rtl/sd_dma_pkg.sv
// Shared types and Wishbone constants for the SD block DMA engine.
package sd_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREF,
    S_BURST,
    S_GAP,
    S_WBUF,
    S_FIN
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Ceiling log2 for parameter arithmetic; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sd_dma_timeout.sv
// Ack timeout: counts strobe cycles and flags expiry on the TIMEOUT_CYC-th one.
module sd_dma_timeout
  import sd_dma_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);
  localparam int CW = (clog2(TIMEOUT_CYC + 1) < 1) ? 1 : clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Zero disables; otherwise expire in the cycle the count would reach TIMEOUT_CYC.
  assign expire_o = (TIMEOUT_CYC != 0) && en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/sd_wb_dma.sv
// Wishbone burst DMA moving one SD block between the block buffer and system memory.
module sd_wb_dma
  import sd_dma_pkg::*;
#(
  parameter int BUF_AW      = 7,
  parameter int BURST_LEN   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              xfer_go,
  input  logic              xfer_dir,
  input  logic [31:0]       xfer_addr,
  output logic              xfer_busy,
  output logic              xfer_done,
  output logic              xfer_err,
  output logic [BUF_AW-1:0] buf_rd_addr,
  input  logic [31:0]       buf_rd_q,
  output logic [BUF_AW-1:0] buf_wr_addr,
  output logic              buf_wr_en,
  output logic [31:0]       buf_wr_data,
  output logic [31:0]       wbm_adr_o,
  input  logic [31:0]       wbm_dat_i,
  output logic [31:0]       wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic [2:0]        wbm_cti_o,
  output logic [1:0]        wbm_bte_o
);
  localparam logic [BUF_AW-1:0] BMASK = BUF_AW'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [BUF_AW-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              dir_q;
  logic [31:0]       base_q;
  logic              wr_en_q;
  logic [BUF_AW-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;

  logic in_burst, tmo, abort, beat_ok, last_in_burst, last_in_block;

  assign in_burst      = (state_q == S_BURST);
  // A timeout coinciding with an ack lets the beat complete; a bus error never does.
  assign abort         = in_burst && (wbm_err_i || (tmo && !wbm_ack_i));
  assign beat_ok       = in_burst && wbm_ack_i && !abort;
  assign last_in_burst = ((idx_q & BMASK) == BMASK);
  assign last_in_block = &idx_q;

  sd_dma_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk_i   (clk_50),
    .rst_ni  (reset_n),
    .en_i    (in_burst),
    .clr_i   (!in_burst || wbm_ack_i),
    .expire_o(tmo)
  );

  // Next state, word index and abort flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (xfer_go) begin
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = xfer_dir ? S_PREF : S_BURST;
      end
      S_PREF:  state_d = S_BURST;
      S_BURST: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (beat_ok) begin
          idx_d = idx_q + 1'b1;
          if (last_in_burst) begin
            if (!last_in_block) state_d = S_GAP;
            else                state_d = dir_q ? S_FIN : S_WBUF;
          end
        end
      end
      S_GAP:   state_d = S_BURST;
      S_WBUF:  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, index and abort flag registers.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Capture direction and word-aligned base on an accepted go.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      dir_q  <= 1'b0;
      base_q <= '0;
    end else if (state_q == S_IDLE && xfer_go) begin
      dir_q  <= xfer_dir;
      base_q <= {xfer_addr[31:2], 2'b00};
    end
  end

  // Read path: each acked word lands in the buffer the following cycle.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= beat_ok && !dir_q;
      if (beat_ok) begin
        wr_addr_q <= idx_q;
        wr_data_q <= wbm_dat_i;
      end
    end
  end

  // Look one word ahead on ack so registered buffer data is ready for the next beat.
  assign buf_rd_addr = beat_ok ? idx_q + 1'b1 : idx_q;
  assign buf_wr_en   = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;

  assign wbm_cyc_o = in_burst;
  assign wbm_stb_o = in_burst;
  assign wbm_we_o  = in_burst && dir_q;
  assign wbm_adr_o = in_burst ? base_q + 32'({idx_q, 2'b00}) : 32'd0;
  assign wbm_dat_o = (in_burst && dir_q) ? buf_rd_q : 32'd0;
  assign wbm_sel_o = 4'hF;
  assign wbm_bte_o = BTE_LINEAR;
  assign wbm_cti_o = !in_burst        ? CTI_CLASSIC :
                     (BURST_LEN == 1) ? CTI_CLASSIC :
                     last_in_burst    ? CTI_EOB : CTI_INCR;

  assign xfer_busy = (state_q != S_IDLE) && (state_q != S_FIN);
  assign xfer_done = (state_q == S_FIN);
  assign xfer_err  = (state_q == S_FIN) && err_q;

endmodule

// File: tb/tb_sd_wb_dma.sv
`timescale 1ns/1ps
module tb_sd_wb_dma;
  localparam int AW  = 7;
  localparam int NW  = 1 << AW;
  localparam int BL  = 8;
  localparam int TMO = 16;
  localparam logic [31:0] K2 = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main DUT: 128-word block, 8-beat bursts, 16-cycle timeout
  logic          go, dir, busy, done, xerr, wr_en, cyc, stb, we, ack, err;
  logic [31:0]   addr, rd_q, wr_data, adr, dat_i, dat_o;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [3:0]    sel;
  logic [2:0]    cti;
  logic [1:0]    bte;

  // second DUT: 4-word block, single-beat classic cycles
  logic        go2, dir2, busy2, done2, err2o, wr_en2, cyc2, stb2, we2, ack2, err2_i;
  logic [31:0] addr2, wr_data2, adr2, dat2_i, dat2_o;
  logic [31:0] rd_q2 = 32'd0;
  logic [1:0]  rd_addr2, wr_addr2;
  logic [3:0]  sel2;
  logic [2:0]  cti2;
  logic [1:0]  bte2;

  sd_wb_dma #(.BUF_AW(AW), .BURST_LEN(BL), .TIMEOUT_CYC(TMO)) dut (
    .clk_50(clk), .reset_n(rst_n), .xfer_go(go), .xfer_dir(dir), .xfer_addr(addr),
    .xfer_busy(busy), .xfer_done(done), .xfer_err(xerr),
    .buf_rd_addr(rd_addr), .buf_rd_q(rd_q), .buf_wr_addr(wr_addr), .buf_wr_en(wr_en),
    .buf_wr_data(wr_data), .wbm_adr_o(adr), .wbm_dat_i(dat_i), .wbm_dat_o(dat_o),
    .wbm_sel_o(sel), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_cti_o(cti), .wbm_bte_o(bte));

  sd_wb_dma #(.BUF_AW(2), .BURST_LEN(1), .TIMEOUT_CYC(TMO)) dut2 (
    .clk_50(clk), .reset_n(rst_n), .xfer_go(go2), .xfer_dir(dir2), .xfer_addr(addr2),
    .xfer_busy(busy2), .xfer_done(done2), .xfer_err(err2o),
    .buf_rd_addr(rd_addr2), .buf_rd_q(rd_q2), .buf_wr_addr(wr_addr2), .buf_wr_en(wr_en2),
    .buf_wr_data(wr_data2), .wbm_adr_o(adr2), .wbm_dat_i(dat2_i), .wbm_dat_o(dat2_o),
    .wbm_sel_o(sel2), .wbm_cyc_o(cyc2), .wbm_stb_o(stb2), .wbm_we_o(we2),
    .wbm_ack_i(ack2), .wbm_err_i(err2_i), .wbm_cti_o(cti2), .wbm_bte_o(bte2));

  typedef struct { logic [31:0] adr; logic we; logic [31:0] dat; logic [2:0] cti; } beat_t;
  typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;

  beat_t       exp_b[$];
  wr_t         exp_w[$];
  logic        exp_d[$];
  logic [31:0] exp2[$];
  logic [31:0] exp2w[$];

  int checks = 0, errors = 0;
  int ncyc = 0, n2 = 0, go_cyc, done_cyc, stb_rise, ndone = 0, done2_cyc = 0, g2;
  int wait_n = 0, err_beat = 1000, wcnt = 0, beat_n = 0;
  logic stb_prev = 1'b0;

  // block buffer model with one-cycle registered read and a whole-block prefill
  logic [31:0] bmem [NW];
  logic        pf_req = 1'b0;
  logic [31:0] pf_base = 32'd0;
  always @(posedge clk) begin
    if (pf_req) for (int i = 0; i < NW; i++) bmem[i] <= pf_base + 32'(i);
    else if (wr_en) bmem[wr_addr] <= wr_data;
    rd_q <= bmem[rd_addr];
  end

  // system memory contents as a pure function of the byte address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C5A_96F1 ^ (a << 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected nothing", nm, act);
  endtask

  // Wishbone slave for the main DUT: ack after wait_n stall cycles; err (with ack) on beat err_beat
  initial begin
    ack = 1'b0; err = 1'b0; dat_i = 32'd0;
    forever begin
      @(negedge clk);
      ack = 1'b0; err = 1'b0;
      if (cyc && stb && rst_n) begin
        dat_i = memf(adr);
        if (wcnt >= wait_n) begin
          wcnt = 0;
          ack  = 1'b1;
          if (beat_n == err_beat) err = 1'b1;
          beat_n++;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // slave for the second DUT: zero-wait ack
  initial begin
    ack2 = 1'b0; dat2_i = 32'd0; err2_i = 1'b0;
    forever begin
      @(negedge clk);
      ack2   = cyc2 && stb2;
      dat2_i = adr2 ^ K2;
    end
  end

  // monitor for the main DUT: pops expectations on every handshake, buffer write and done
  initial begin
    beat_t b;
    wr_t   w;
    forever begin
      @(negedge clk); #1;
      ncyc++;
      if (stb && !stb_prev) stb_rise = ncyc;
      stb_prev = stb;
      if (cyc && stb && ack && !err) begin
        if (exp_b.size() == 0) fail("extra_beat", adr);
        else begin
          b = exp_b.pop_front();
          chk("beat_adr", adr, b.adr);
          chk("beat_we", 32'(we), 32'(b.we));
          chk("beat_cti", 32'(cti), 32'(b.cti));
          chk("beat_sel", 32'(sel), 32'hF);
          if (b.we) chk("beat_dat", dat_o, b.dat);
        end
      end
      if (wr_en) begin
        if (exp_w.size() == 0) fail("extra_buf_write", 32'(wr_addr));
        else begin
          w = exp_w.pop_front();
          chk("buf_wr_addr", 32'(wr_addr), 32'(w.a));
          chk("buf_wr_data", wr_data, w.d);
        end
      end
      if (done) begin
        done_cyc = ncyc;
        ndone++;
        if (exp_d.size() == 0) fail("unexpected_done", 32'(xerr));
        else chk("done_err", 32'(xerr), 32'(exp_d.pop_front()));
        chk("busy_at_done", 32'(busy), 0);
        chk("cyc_at_done", 32'(cyc), 0);
        chk("beats_left_at_done", 32'(exp_b.size()), 0);
        chk("writes_left_at_done", 32'(exp_w.size()), 0);
      end
    end
  end

  // monitor for the second DUT
  initial begin
    forever begin
      @(negedge clk); #1;
      n2++;
      if (cyc2 && stb2 && ack2) begin
        chk("b2_cti", 32'(cti2), 32'(3'b000));
        if (exp2.size() == 0) fail("b2_extra_beat", adr2);
        else chk("b2_adr", adr2, exp2.pop_front());
      end
      if (wr_en2) begin
        if (exp2w.size() == 0) fail("b2_extra_write", wr_data2);
        else chk("b2_wr_data", wr_data2, exp2w.pop_front());
      end
      if (done2) begin
        done2_cyc = n2;
        chk("b2_err", 32'(err2o), 0);
      end
    end
  end

  task automatic prefill(input logic [31:0] base);
    @(negedge clk); #2; pf_base = base; pf_req = 1'b1;
    @(negedge clk); #2; pf_req = 1'b0;
  endtask

  // reference model: expected beats, buffer writes and completion for one transfer, then go
  task automatic launch(input logic d, input logic [31:0] a, input int wn, input int eb,
                        input logic never);
    logic [31:0] b;
    int nb;
    b  = {a[31:2], 2'b00};
    nb = never ? 0 : ((eb < NW) ? eb : NW);
    for (int i = 0; i < nb; i++) begin
      beat_t x;
      x.adr = b + 32'(4 * i);
      x.we  = d;
      x.dat = pf_base + 32'(i);
      x.cti = ((i % BL) == BL - 1) ? 3'b111 : 3'b010;
      exp_b.push_back(x);
      if (!d) exp_w.push_back('{AW'(i), memf(x.adr)});
    end
    exp_d.push_back(never || (eb < NW));
    @(negedge clk); #2;
    wait_n = never ? (1 << 30) : wn; err_beat = eb; wcnt = 0; beat_n = 0;
    go = 1'b1; dir = d; addr = a; go_cyc = ncyc;
    @(negedge clk); #2;
    go = 1'b0; dir = 1'($urandom); addr = $urandom;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int n;
    n = 0;
    while (!done && n < maxc) begin @(negedge clk); #2; n++; end
    if (!done) fail(nm, 32'(n));
    @(negedge clk); #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nbad, nd0;
    rst_n = 1'b0; go = 1'b0; dir = 1'b0; addr = 32'd0;
    go2 = 1'b0; dir2 = 1'b0; addr2 = 32'd0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_cyc", 32'(cyc), 0);       chk("rst_stb", 32'(stb), 0);
    chk("rst_we", 32'(we), 0);         chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);     chk("rst_err", 32'(xerr), 0);
    chk("rst_adr", adr, 0);            chk("rst_cti", 32'(cti), 0);
    chk("rst_bte", 32'(bte), 0);       chk("rst_sel", 32'(sel), 32'hF);
    chk("rst_wr_en", 32'(wr_en), 0);   chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0); chk("rst_wr_data", wr_data, 0);
    chk("rst_dat_o", dat_o, 0);
    chk("rst2_cyc", 32'(cyc2), 0);     chk("rst2_sel", 32'(sel2), 32'hF);
    chk("rst2_bte", 32'(bte2), 0);     chk("rst2_busy", 32'(busy2), 0);
    chk("rst2_we", 32'(we2), 0);       chk("rst2_dat_o", dat2_o, 0);
    chk("rst2_rd_addr", 32'(rd_addr2), 0); chk("rst2_done", 32'(done2), 0);
    chk("rst2_wr_en", 32'(wr_en2), 0); chk("rst2_stb", 32'(stb2), 0);
    chk("rst2_err", 32'(err2o), 0);    chk("rst2_cti", 32'(cti2), 0);
    rst_n = 1'b1;

    // read, zero-wait slave: done in the 146th cycle counting the go cycle as the first
    prefill(32'hDEAD_0000);
    launch(1'b0, 32'h1000_0000, 0, 1000, 1'b0);
    wait_done("read_done_timeout", 400);
    chk("read_latency", 32'(done_cyc - go_cyc), 32'd145);
    nbad = 0;
    for (int i = 0; i < NW; i++) if (bmem[i] !== memf(32'h1000_0000 + 32'(4 * i))) nbad++;
    chk("read_buffer_words_bad", 32'(nbad), 0);

    // write with stalls; a go pulsed mid-transfer must be ignored
    prefill(32'hA500_0000);
    launch(1'b1, 32'h2000_0010, 2, 1000, 1'b0);
    repeat (40) @(negedge clk);
    #2; go = 1'b1; dir = 1'b0; addr = 32'h0BAD_0000;
    @(negedge clk); #2; go = 1'b0;
    wait_done("write_done_timeout", 1000);

    // bus error on beat 37 (arrives together with ack)
    prefill(32'h7700_0000);
    launch(1'b0, 32'h3000_0000, 0, 37, 1'b0);
    wait_done("err_done_timeout", 200);
    nbad = 0;
    for (int i = 0; i < 37; i++) if (bmem[i] !== memf(32'h3000_0000 + 32'(4 * i))) nbad++;
    for (int i = 37; i < NW; i++) if (bmem[i] !== 32'h7700_0000 + 32'(i)) nbad++;
    chk("err_buffer_words_bad", 32'(nbad), 0);

    // slave never acks
    launch(1'b0, 32'h4000_0000, 0, 1000, 1'b1);
    wait_done("tmo_done_timeout", 100);
    chk("tmo_latency", 32'(done_cyc - stb_rise), 32'd16);
    chk("tmo_busy_after", 32'(busy), 0);

    // asynchronous reset mid-burst: bus drops at once, no done
    launch(1'b0, 32'h5000_0000, 0, 1000, 1'b0);
    repeat (20) @(negedge clk);
    #2; nd0 = ndone; rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(cyc), 0);
    chk("arst_stb", 32'(stb), 0);
    chk("arst_busy", 32'(busy), 0);
    exp_b.delete(); exp_w.delete(); exp_d.delete();
    repeat (3) @(negedge clk);
    #2; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_no_done", 32'(ndone), 32'(nd0));
    prefill(32'h1234_0000);
    launch(1'b0, 32'h5000_1000, 1, 1000, 1'b0);
    wait_done("post_reset_done_timeout", 600);

    // randomized transfers, one of them wrapping past 2^32
    for (int t = 0; t < 4; t++) begin
      logic        rd;
      logic [31:0] ra;
      rd = 1'($urandom);
      ra = (t == 0) ? 32'hFFFF_FF83 : $urandom;
      prefill($urandom);
      launch(rd, ra, int'($urandom_range(0, 2)), 1000, 1'b0);
      wait_done("rand_done_timeout", 1000);
    end

    // single-beat configuration: 4 classic cycles separated by gaps
    for (int i = 0; i < 4; i++) begin
      exp2.push_back(32'h0000_0100 + 32'(4 * i));
      exp2w.push_back((32'h0000_0100 + 32'(4 * i)) ^ K2);
    end
    @(negedge clk); #2; go2 = 1'b1; addr2 = 32'h0000_0103; g2 = n2;
    @(negedge clk); #2; go2 = 1'b0;
    for (int n = 0; n < 50 && !done2; n++) begin @(negedge clk); #2; end
    chk("b2_done_seen", 32'(done2), 1);
    chk("b2_latency", 32'(done2_cyc - g2), 32'd9);
    @(negedge clk); #2;
    chk("b2_beats_left", 32'(exp2.size()), 0);
    chk("b2_writes_left", 32'(exp2w.size()), 0);

    chk("final_beats_left", 32'(exp_b.size()), 0);
    chk("final_done_left", 32'(exp_d.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
